alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-port arbiter and sequencer that time-shares one instance of the team's 32-bit combinational ALU between two requesters, e.g. the integer pipeline and an address/debug unit. Each requester has a valid/ready request channel and a valid/ready response channel. Grants are round-robin. Operands are registered into a single issue stage that drives the shared ALU. The ALU result and zero flag are captured into a per-requester response register.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must equal the shared ALU width (32).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- req0_valid / req1_valid  input  1  request offered by requester 0 / 1
- req0_ready / req1_ready  output  1  request accepted this cycle (grant)
- req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands A and B
- req0_op / req1_op  input  3  ALU op: 000 ADD, 001 SUB, 010 AND, 110 OR, 111 SLT (unsigned)
- rsp0_valid / rsp1_valid  output  1  response held for requester 0 / 1
- rsp0_ready / rsp1_ready  input  1  requester consumes response
- rsp0_result / rsp1_result  output  DATA_W  captured ALU result
- rsp0_zero / rsp1_zero  output  1  captured ALU zero flag
- alu_src_A, alu_src_B  output  DATA_W  to shared ALU operand inputs
- alu_control  output  3  to shared ALU op input
- alu_result  input  DATA_W  from shared ALU
- alu_zero  input  1  from shared ALU

## Operation
- Issue stage registers: s1_valid, s1_id, s1_a, s1_b, s1_op. The ALU inputs are driven directly from s1_a, s1_b and s1_op.
- Requester i is busy when either holds:
  - s1_valid && s1_id==i, or
  - rsp_valid_i && !rsp_ready_i.
- A response being consumed this cycle frees the slot in the same cycle.
- eligible_i = req_valid_i && !busy_i. At most one grant per cycle. reqi_ready = grant_i and is combinational from eligibility.
- Round-robin arbitration:
  - Register last_id.
  - If both requesters are eligible, grant the one != last_id.
  - If only one is eligible, grant it.
  - last_id updates only on a grant.
- On grant: s1 <= {1, i, a_i, b_i, op_i}. With no grant: s1_valid <= 0, and the operand registers hold their values.
- When s1_valid, at the clock edge: rsp_result_{s1_id} <= alu_result, rsp_zero_{s1_id} <= alu_zero, rsp_valid_{s1_id} <= 1.
- rsp_valid_i clears on rsp_valid_i && rsp_ready_i unless a new capture for i happens in the same edge. The busy rule prevents that overlap.
- The result is held stable while rsp_valid && !rsp_ready.
- Op codes 011/100/101 are forwarded unchanged. The response is whatever the ALU returns (0, zero=1).
- No reordering: each requester has at most one operation outstanding, so its responses return in order.

## Timing
- Reset values (rst_n low at an edge): s1_valid=0, s1_a=s1_b=0, s1_op=000, last_id=1 (requester 0 wins the first tie), rsp*_valid=0, rsp*_result=0, rsp*_zero=0.
- While rst_n=0, req*_ready is forced to 0.
- Reset mid-operation: in-flight and unconsumed results are discarded, with no response emitted.
- Latency: request accepted at edge N. Operands are in s1 during cycle N+1. rsp_valid is high from cycle N+2.
- Per-requester issue interval is 2 cycles with rsp_ready held high: re-accept happens in the cycle the previous response is consumed.
- Two requesters alternating keep the ALU busy every cycle.
- The ALU is combinational: alu_result must settle within one cycle from the s1 registers.
- Request channel: the requester holds valid and its operands until ready. Dropping valid before a grant is allowed.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both req_valid=1.
  - Expect ready=0, rsp_valid=0, results=0, alu_* =0.
  - First cycle after release: req0_ready=1.
- Single op: req0 ADD a=5, b=7 at edge N.
  - Expect rsp0_valid at N+2 with result=12, zero=0.
  - req0 SUB 9-9 → result=0, zero=1.
- Contention: both requesters valid every cycle, rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - Responses: req1 SLT 0xFFFFFFFF<1 → 0; req0 SLT 1<0xFFFFFFFF → 1; OR 0xF0|0x0F → 0xFF; AND → correct.
- Backpressure: rsp0_ready=0 for 5 cycles with req0_valid=1.
  - req0_ready stays 0 and rsp0_result stays stable.
  - req1 is still granted each time it is free.
- Release: raise rsp0_ready.
  - The next req0 is accepted in the same cycle, and its response appears 2 cycles later.
- Reset mid-flight: assert rst_n=0 one cycle after a grant.
  - Expect no response for that op.
  - After reset, last_id=1 (requester 0 wins the next tie).

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that time-shares one combinational ALU between two
// valid/ready requesters, with a single issue stage and per-requester response registers.
module alu_share_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_src_A,
  output logic [DATA_W-1:0] alu_src_B,
  output logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  logic              s1_valid;
  logic              s1_id;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [2:0]        s1_op;
  logic              last_id;

  logic busy0, busy1, elig0, elig1, grant0, grant1;

  // A requester stays busy until its response is consumed, which keeps at most
  // one operation outstanding per requester and rules out capture/consume overlap.
  assign busy0 = (s1_valid && !s1_id) || (rsp0_valid && !rsp0_ready);
  assign busy1 = (s1_valid &&  s1_id) || (rsp1_valid && !rsp1_ready);
  assign elig0 = req0_valid && !busy0;
  assign elig1 = req1_valid && !busy1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (elig0 && elig1) begin
        grant0 = last_id;
        grant1 = !last_id;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---- issue stage: operands held in s1 drive the shared ALU ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= 3'b000;
      last_id  <= 1'b1;
    end else begin
      s1_valid <= grant0 || grant1;
      if (grant0) begin
        s1_id   <= 1'b0;
        s1_a    <= req0_a;
        s1_b    <= req0_b;
        s1_op   <= req0_op;
        last_id <= 1'b0;
      end else if (grant1) begin
        s1_id   <= 1'b1;
        s1_a    <= req1_a;
        s1_b    <= req1_b;
        s1_op   <= req1_op;
        last_id <= 1'b1;
      end
    end
  end

  assign alu_src_A   = s1_a;
  assign alu_src_B   = s1_b;
  assign alu_control = s1_op;

  // ---- response stage: ALU output captured for the issuing requester ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
    end else if (s1_valid && !s1_id) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_zero   <= alu_zero;
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else if (s1_valid && s1_id) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_zero   <= alu_zero;
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; a behavioural ALU closes the loop on the shared ALU ports.
module tb_alu_share_ctrl;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]        req0_op, req1_op;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic              rsp0_zero, rsp1_zero;
  logic [DATA_W-1:0] alu_src_A, alu_src_B, alu_result;
  logic [2:0]        alu_control;
  logic              alu_zero;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Shared combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_control)
      3'b000:  alu_result = alu_src_A + alu_src_B;
      3'b001:  alu_result = alu_src_A - alu_src_B;
      3'b010:  alu_result = alu_src_A & alu_src_B;
      3'b110:  alu_result = alu_src_A | alu_src_B;
      3'b111:  alu_result = {31'b0, alu_src_A < alu_src_B};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; drive then settle before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, 3'b000, 32'd5, 32'd7);
    set1(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1);

    // Reset held with both requesters valid
    repeat (3) tick();
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_rsp1_result", rsp1_result, 0);
    check("rst_alu_a", alu_src_A, 0);
    check("rst_alu_b", alu_src_B, 0);
    check("rst_alu_ctl", alu_control, 0);

    rst_n = 1'b1;
    #1;
    check("rel_req0_ready", req0_ready, 1);
    check("rel_req1_ready", req1_ready, 0);

    // E1: req0 ADD issued
    tick();
    set0(1'b1, 3'b001, 32'd9, 32'd9);
    #1;
    check("e1_alu_a", alu_src_A, 5);
    check("e1_alu_b", alu_src_B, 7);
    check("e1_alu_ctl", alu_control, 3'b000);
    check("e1_req0_ready", req0_ready, 0);
    check("e1_req1_ready", req1_ready, 1);

    // E2: ADD response, req1 SLT issued
    tick();
    set1(1'b1, 3'b110, 32'h0000_00F0, 32'h0000_000F);
    #1;
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp0_result", rsp0_result, 12);
    check("add_rsp0_zero", rsp0_zero, 0);
    check("e2_req0_ready", req0_ready, 1);
    check("e2_req1_ready", req1_ready, 0);

    // E3: SLT response for req1, req0 SUB issued
    tick();
    set0(1'b1, 3'b111, 32'd1, 32'hFFFF_FFFF);
    #1;
    check("e3_rsp0_valid", rsp0_valid, 0);
    check("slt1_rsp1_valid", rsp1_valid, 1);
    check("slt1_rsp1_result", rsp1_result, 0);
    check("slt1_rsp1_zero", rsp1_zero, 1);
    check("e3_req1_ready", req1_ready, 1);
    check("e3_req0_ready", req0_ready, 0);

    // E4: SUB response, req1 OR issued
    tick();
    set1(1'b1, 3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0);
    #1;
    check("sub_rsp0_valid", rsp0_valid, 1);
    check("sub_rsp0_result", rsp0_result, 0);
    check("sub_rsp0_zero", rsp0_zero, 1);
    check("e4_rsp1_valid", rsp1_valid, 0);
    check("e4_req0_ready", req0_ready, 1);
    check("e4_req1_ready", req1_ready, 0);

    // E5: OR response, req0 SLT issued
    tick();
    set0(1'b1, 3'b000, 32'h10, 32'h20);
    #1;
    check("or_rsp1_result", rsp1_result, 32'hFF);
    check("or_rsp1_zero", rsp1_zero, 0);
    check("e5_rsp0_valid", rsp0_valid, 0);
    check("e5_req1_ready", req1_ready, 1);
    check("e5_req0_ready", req0_ready, 0);

    // E6: SLT response for req0, req1 AND issued; then backpressure req0
    tick();
    check("slt0_rsp0_result", rsp0_result, 1);
    check("slt0_rsp0_zero", rsp0_zero, 0);
    rsp0_ready = 1'b0;
    set1(1'b1, 3'b000, 32'd1, 32'd2);
    #1;
    check("bp_start_req0_ready", req0_ready, 0);

    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("bp_req0_ready", req0_ready, 0);
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_rsp0_result", rsp0_result, 1);
      check("bp_req1_ready", req1_ready, (k % 2 == 0));
      if (k == 0) check("and_rsp1_result", rsp1_result, 32'h0F00_0F00);
      if (k == 2) check("bp_rsp1_result", rsp1_result, 3);
    end

    // Release: req0 accepted in the same cycle its response is consumed
    rsp0_ready = 1'b1;
    #1;
    check("rls_req0_ready", req0_ready, 1);
    check("rls_req1_ready", req1_ready, 0);
    tick();
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    set1(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    check("rls_rsp0_valid_n1", rsp0_valid, 0);
    check("rls_alu_a", alu_src_A, 32'h10);
    tick();
    #1;
    check("rls_rsp0_valid_n2", rsp0_valid, 1);
    check("rls_rsp0_result", rsp0_result, 32'h30);

    // Reset one cycle after a grant: the in-flight op must vanish
    tick();
    set0(1'b1, 3'b000, 32'd2, 32'd3);
    #1;
    check("mid_req0_ready", req0_ready, 1);
    tick();
    rst_n = 1'b0;
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    tick();
    #1;
    check("mid_rsp0_valid_a", rsp0_valid, 0);
    check("mid_req0_ready_rst", req0_ready, 0);
    tick();
    #1;
    check("mid_rsp0_valid_b", rsp0_valid, 0);
    rst_n = 1'b1;
    set0(1'b1, 3'b000, 32'd4, 32'd4);
    set1(1'b1, 3'b000, 32'd1, 32'd1);
    #1;
    check("post_req0_ready", req0_ready, 1);
    check("post_req1_ready", req1_ready, 0);
    tick();
    set0(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    check("post_rsp0_valid_n1", rsp0_valid, 0);
    check("post_req1_ready_n1", req1_ready, 1);
    tick();
    set1(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    check("post_rsp0_valid_n2", rsp0_valid, 1);
    check("post_rsp0_result", rsp0_result, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
